// File: rtl/rv_pkg.sv
// Shared integer register-file types and constants for the writeback path.
package rv_pkg;
    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = $clog2(NREG);

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared at writeback.
module rf_scoreboard
    import rv_pkg::*;
#(
    parameter int NREG = rv_pkg::NREG,
    parameter int IW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic            issue_wr,
    input  logic [IW-1:0]   issue_rd,
    input  logic [IW-1:0]   issue_rs1,
    input  logic [IW-1:0]   issue_rs2,
    input  logic            clr_en,
    input  logic [IW-1:0]   clr_rd,
    output logic            issue_stall,
    output logic [NREG-1:0] busy_vec
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            set_en;

    // Deliberately blind to same-cycle clears; the stall only sees registered state.
    assign issue_stall = busy_q[issue_rs1] | busy_q[issue_rs2] | (issue_wr & busy_q[issue_rd]);
    assign set_en      = issue_valid & ~issue_stall & issue_wr & (issue_rd != REG_ZERO);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[issue_rd] = 1'b1;
        if (clr_en) clr_mask[clr_rd]   = 1'b1;
    end

    // Set is OR'd in after the clear so a colliding set wins; bit 0 is forced low.
    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= ((busy_q & ~clr_mask) | set_mask) & {{(NREG-1){1'b1}}, 1'b0};
    end

    assign busy_vec = busy_q;
endmodule

// File: rtl/rf_wb_sched.sv
// Writeback arbiter (ALU/LSU onto one RF write port) with pending-write scoreboard.
// Define RF_WB_RR_EN for round-robin arbitration; default is fixed priority LSU > ALU.
module rf_wb_sched
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int NREG = rv_pkg::NREG
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic                    issue_wr,
    input  logic [$clog2(NREG)-1:0] issue_rd,
    input  logic [$clog2(NREG)-1:0] issue_rs1,
    input  logic [$clog2(NREG)-1:0] issue_rs2,
    output logic                    issue_stall,
    input  logic                    alu_valid,
    input  logic [$clog2(NREG)-1:0] alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    output logic                    alu_ready,
    input  logic                    lsu_valid,
    input  logic [$clog2(NREG)-1:0] lsu_rd,
    input  logic [XLEN-1:0]         lsu_data,
    output logic                    lsu_ready,
    output logic                    rf_we,
    output logic [$clog2(NREG)-1:0] rf_rd,
    output logic [XLEN-1:0]         rf_wdata,
    output logic [NREG-1:0]         busy_vec
);
    wb_req_t alu_req;
    wb_req_t lsu_req;
    wb_req_t win;
    logic    pick_lsu;

    assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};

`ifdef RF_WB_RR_EN
    logic last_lsu;

    // Reset value 0 means "ALU went last", so the LSU is favoured first.
    assign pick_lsu = lsu_valid & (~alu_valid | ~last_lsu);

    always_ff @(posedge clk) begin
        if (reset)                       last_lsu <= 1'b0;
        else if (alu_ready | lsu_ready)  last_lsu <= lsu_ready;
    end
`else
    assign pick_lsu = lsu_valid;
`endif

    assign lsu_ready = ~reset & pick_lsu;
    assign alu_ready = ~reset & alu_valid & ~pick_lsu;

    always_comb begin
        win = '0;
        if (lsu_ready)      win = lsu_req;
        else if (alu_ready) win = alu_req;
    end

    // x0 writes still consume the port cycle but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= win.valid & (win.rd != REG_ZERO);
            if (win.valid) begin
                rf_rd    <= win.rd;
                rf_wdata <= win.data;
            end
        end
    end

    rf_scoreboard #(.NREG(NREG)) u_sb (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .clr_en      (win.valid),
        .clr_rd      (win.rd),
        .issue_stall (issue_stall),
        .busy_vec    (busy_vec)
    );
endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed vector bench for rf_wb_sched; contention expectations follow RF_WB_RR_EN.
module tb_rf_wb_sched;
    logic        clk;
    logic        reset;
    logic        issue_valid, issue_wr;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] busy_vec;

    int n_cmp = 0;
    int n_bad = 0;

    rf_wb_sched dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv, iw;
        logic [4:0]  ird, rs1, rs2;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        e_stall, e_ardy, e_lrdy, e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
    } vec_t;

    function automatic vec_t mk(
        logic rst, logic iv, logic iw, logic [4:0] ird, logic [4:0] rs1, logic [4:0] rs2,
        logic av, logic [4:0] ard, logic [31:0] adat,
        logic lv, logic [4:0] lrd, logic [31:0] ldat,
        logic e_stall, logic e_ardy, logic e_lrdy, logic e_we,
        logic [4:0] e_rd, logic [31:0] e_wd, logic [31:0] e_busy);
        vec_t t;
        t.rst = rst; t.iv = iv; t.iw = iw; t.ird = ird; t.rs1 = rs1; t.rs2 = rs2;
        t.av = av; t.ard = ard; t.adat = adat; t.lv = lv; t.lrd = lrd; t.ldat = ldat;
        t.e_stall = e_stall; t.e_ardy = e_ardy; t.e_lrdy = e_lrdy; t.e_we = e_we;
        t.e_rd = e_rd; t.e_wd = e_wd; t.e_busy = e_busy;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive, check combinational outputs at negedge, check registered outputs after posedge.
    task automatic apply(input vec_t t, input string tag);
        reset = t.rst; issue_valid = t.iv; issue_wr = t.iw; issue_rd = t.ird;
        issue_rs1 = t.rs1; issue_rs2 = t.rs2;
        alu_valid = t.av; alu_rd = t.ard; alu_data = t.adat;
        lsu_valid = t.lv; lsu_rd = t.lrd; lsu_data = t.ldat;
        @(negedge clk);
        if (!t.rst) chk({tag, ".stall"}, {31'd0, issue_stall}, {31'd0, t.e_stall});
        chk({tag, ".alu_ready"}, {31'd0, alu_ready}, {31'd0, t.e_ardy});
        chk({tag, ".lsu_ready"}, {31'd0, lsu_ready}, {31'd0, t.e_lrdy});
        @(posedge clk);
        #1;
        chk({tag, ".rf_we"}, {31'd0, rf_we}, {31'd0, t.e_we});
        if (t.e_we || t.rst) begin
            chk({tag, ".rf_rd"}, {27'd0, rf_rd}, {27'd0, t.e_rd});
            chk({tag, ".rf_wdata"}, rf_wdata, t.e_wd);
        end
        chk({tag, ".busy"}, busy_vec, t.e_busy);
    endtask

    vec_t tbl[17];

    initial begin
        //              rst iv iw ird rs1 rs2  av ard adat          lv lrd ldat        stl ar lr we rd  wd            busy
        tbl[0]  = mk(1, 0, 0, 0,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        32'h0);
        tbl[1]  = mk(0, 1, 1, 5,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        32'h20);
        tbl[2]  = mk(0, 0, 0, 0,  0,  0,   1, 5,  32'hAA,       0, 0,  32'h0,        0, 1, 0, 1, 5,  32'hAA,       32'h0);
        tbl[3]  = mk(0, 1, 1, 7,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        32'h80);
        tbl[4]  = mk(0, 1, 1, 8,  7,  0,   0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0, 0, 0,  32'h0,        32'h80);
        tbl[5]  = mk(0, 0, 0, 0,  7,  0,   0, 0,  32'h0,        1, 7,  32'h12345678, 1, 0, 1, 1, 7,  32'h12345678, 32'h0);
        tbl[6]  = mk(0, 0, 0, 0,  7,  0,   0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        32'h0);
        tbl[7]  = mk(0, 1, 1, 0,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        32'h0);
        tbl[8]  = mk(0, 0, 0, 0,  0,  0,   1, 0,  32'hFFFFFFFF, 0, 0,  32'h0,        0, 1, 0, 0, 0,  32'h0,        32'h0);
        tbl[9]  = mk(0, 1, 1, 9,  0,  0,   0, 0,  32'h0,        1, 9,  32'h99,       0, 0, 1, 1, 9,  32'h99,       32'h200);
        tbl[10] = mk(0, 0, 0, 0,  0,  0,   1, 9,  32'h9A,       0, 0,  32'h0,        0, 1, 0, 1, 9,  32'h9A,       32'h0);
        tbl[11] = mk(0, 1, 1, 3,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        32'h8);
        tbl[12] = mk(0, 0, 0, 0,  0,  3,   0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0, 0, 0,  32'h0,        32'h8);
        tbl[13] = mk(0, 1, 1, 3,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0, 0, 0,  32'h0,        32'h8);
        tbl[14] = mk(0, 1, 0, 3,  0,  0,   0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,        32'h8);
        tbl[15] = mk(0, 0, 0, 0,  0,  0,   1, 3,  32'h33,       1, 4,  32'h44,       0, 0, 1, 1, 4,  32'h44,       32'h8);
        tbl[16] = mk(0, 0, 0, 0,  0,  0,   1, 3,  32'h33,       0, 0,  32'h0,        0, 1, 0, 1, 3,  32'h33,       32'h0);

        for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("v%0d", i));

        // Sustained contention; the previous grant went to the ALU.
        for (int i = 0; i < 4; i++) begin
            logic g_lsu;
`ifdef RF_WB_RR_EN
            g_lsu = (i % 2 == 0);
`else
            g_lsu = 1'b1;
`endif
            apply(mk(0, 0, 0, 0, 0, 0, 1, 10, 32'hA0, 1, 11, 32'hB0,
                     0, !g_lsu, g_lsu, 1, g_lsu ? 5'd11 : 5'd10,
                     g_lsu ? 32'hB0 : 32'hA0, 32'h0), $sformatf("cont%0d", i));
        end

        // Reset the cycle after a grant, with requesters still asserting valid.
        apply(mk(0, 1, 1, 13, 0, 0, 0, 0,  32'h0,  0, 0,  32'h0, 0, 0, 0, 0, 0,  32'h0,  32'h2000), "mr_set");
        apply(mk(0, 0, 0, 0,  0, 0, 1, 12, 32'hC0, 0, 0,  32'h0, 0, 1, 0, 1, 12, 32'hC0, 32'h2000), "mr_gnt");
        apply(mk(1, 0, 0, 0,  0, 0, 1, 12, 32'hC1, 1, 14, 32'hD0, 0, 0, 0, 0, 0, 32'h0,  32'h0),    "mr_rst");
        apply(mk(0, 0, 0, 0,  0, 0, 0, 0,  32'h0,  0, 0,  32'h0, 0, 0, 0, 0, 0,  32'h0,  32'h0),    "mr_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Writeback scheduler and scoreboard for the 32-entry, single-write-port integer register file.
- Arbitrates the ALU and LSU writeback requesters onto the one write port, then drives the register file's rd, rd_data and rd_valid inputs.
- Keeps a per-register pending-write scoreboard. The issue stage uses it to stall on RAW/WAW hazards.

Parameters:
- XLEN, 32, data width of writeback values.
- NREG, 32, number of architectural registers; register index width is clog2(NREG).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  issue stage is dispatching an instruction this cycle (only honoured when issue_stall=0).
- issue_wr  in  1  dispatched instruction writes rd.
- issue_rd  in  5  destination register of the dispatched instruction.
- issue_rs1  in  5  source 1 of the candidate instruction.
- issue_rs2  in  5  source 2 of the candidate instruction.
- issue_stall  out  1  combinational hazard: busy[rs1] | busy[rs2] | (issue_wr & busy[rd]).
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  LSU writeback request.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  XLEN  load result.
- lsu_ready  out  1  LSU request accepted this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  5  register-file write index (registered).
- rf_wdata  out  XLEN  register-file write data (registered).
- busy_vec  out  NREG  scoreboard state, for debug and forwarding.

Behaviour:
- Reset, synchronous: busy_vec=0, rf_we=0, rf_rd=0, rf_wdata=0, arbiter pointer=LSU-favoured. alu_ready and lsu_ready are 0 while reset is high.
- Handshake: a transfer occurs when valid&ready. ready is combinational from the arbiter. A requester holds valid, rd and data stable until accepted.
- Arbitration, default: fixed priority, LSU over ALU. At most one grant per cycle.
- Latency: an accepted request appears on rf_we/rf_rd/rf_wdata on the next cycle, exactly 1 cycle. With no grant, rf_we=0 next cycle.
- x0:
  - A request with rd=0 is still accepted and still consumes the port cycle, but rf_we stays 0.
  - busy[0] is constant 0.
  - issue_wr with issue_rd=0 never sets a bit.
- Scoreboard set: issue_valid & ~issue_stall & issue_wr & issue_rd!=0 sets busy[issue_rd] at the clock edge.
- Scoreboard clear: busy[rd] clears on the same edge that registers the accepted request. The register file and scoreboard therefore update together, and the next cycle reads new data with busy=0.
- Simultaneous set and clear of the same rd: set wins, bit stays 1. issue_stall normally prevents this; it is defined for robustness.
- Writeback to a register whose busy bit is 0: accepted and written; the bit stays 0. This is not an error.
- Reset mid-operation: pending grants are discarded, the output write is cancelled, and all busy bits clear. Requesters must drop valid while reset is high.
- issue_stall is purely combinational from busy_vec and the issue_* ports. It does not look ahead at same-cycle writeback clears.

Optional Feature:
- Macro: RF_WB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_grant register favours the requester not granted last time. On contention the grants alternate, so each source waits at most 1 cycle. last_grant updates only on a grant.
- Undefined: fixed priority LSU>ALU. A continuously valid LSU starves the ALU. No last_grant flop is built.

Decomposition:
- Shared package rv_pkg holds: XLEN, NREG, REG_IDX_W=5, the zero-register constant, and the wb_req struct typedef {valid, rd, data}.
- Natural sub-module: rf_scoreboard, holding the busy bit-vector, set/clear logic and hazard compare.
- Arbitration and output registers stay in the top.

Test Plan:
- Basic write: issue rd=5 (busy[5]=1); next cycle ALU valid rd=5 data=0x0000_00AA.
  - alu_ready=1.
  - Next cycle rf_we=1, rf_rd=5, rf_wdata=0xAA.
  - busy[5]=0 after that edge.
- Contention: ALU rd=3 and LSU rd=4 both valid, held.
  - Default build: LSU granted cycle 0, ALU cycle 1; rf_rd sequence 4 then 3.
  - RF_WB_RR_EN build, both held valid for 4 cycles: grants alternate LSU, ALU, LSU, ALU.
- Hazard stall: busy[7]=1, candidate rs1=7 -> issue_stall=1, and issue_valid does not set a new bit. After writeback of rd=7, issue_stall=0.
- x0 handling: issue_wr with rd=0, then ALU writeback rd=0 data=0xFFFF_FFFF.
  - busy[0] stays 0.
  - Grant still given, rf_we stays 0.
- Set/clear collision: force issue with rd=9 while LSU writes back rd=9 in the same cycle -> busy[9]=1 afterwards.
- Mid-operation reset: reset asserted the cycle after a grant.
  - rf_we=0.
  - busy_vec=0.
  - alu_ready=lsu_ready=0 while reset is high.
